// File: rtl/ps2_key_gen.sv
// PS/2 device-to-host receiver: filters the raw pins, deserialises frames and folds E0/F0/E1 prefixes into ps2_key.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the currently held key.
module ps2_key_gen #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input conditioning
    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic          data_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall_edge;

    // Frame state machine
    state_t        state;
    state_t        state_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic          parity;
    logic          parity_n;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_n;
    logic          byte_ok;
    logic          frame_bad;
    logic          start_err;

    // Prefix folding and event generation
    logic          ext;
    logic          ext_n;
    logic          brk;
    logic          brk_n;
    logic [2:0]    skip;
    logic [2:0]    skip_n;
    logic [10:0]   key_n;
    logic          stb_n;
    logic          err_n;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0]    held;
    logic [8:0]    held_n;
    logic          held_vld;
    logic          held_vld_n;
    logic          repeat_make;
`endif

    always_ff @(posedge clk_sys) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // The filtered clock only moves after FILTER consecutive disagreeing samples.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign fall_edge = filt_clk && !clk_sync && (filt_cnt == FILT_LAST);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            parity  <= parity_n;
            to_cnt  <= to_cnt_n;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave a latch behind.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        parity_n  = parity;
        to_cnt_n  = to_cnt;
        byte_ok   = 1'b0;
        frame_bad = 1'b0;
        start_err = 1'b0;

        if (fall_edge) begin
            // A falling edge always restarts the timeout, even when it coincides with expiry.
            to_cnt_n = '0;
            case (state)
                S_IDLE: begin
                    if (!data_sync) begin
                        state_n   = S_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        start_err = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_n   = {data_sync, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_n = data_sync;
                    state_n  = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    if (data_sync && (^{shift, parity})) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (to_cnt == TO_LAST) begin
                state_n   = S_IDLE;
                to_cnt_n  = '0;
                frame_bad = 1'b1;
            end else begin
                to_cnt_n = to_cnt + TW'(1);
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign repeat_make = !brk && held_vld && (held == {ext, shift});
`endif

    always_comb begin
        ext_n = ext;
        brk_n = brk;
        skip_n = skip;
        key_n = ps2_key;
        stb_n = 1'b0;
        err_n = frame_bad | start_err;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_n     = held;
        held_vld_n = held_vld;
`endif

        if (frame_bad) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end else if (byte_ok) begin
            if (skip != 3'd0) begin
                skip_n = skip - 3'd1;
            end else if (shift == 8'hE0) begin
                ext_n = 1'b1;
            end else if (shift == 8'hF0) begin
                brk_n = 1'b1;
            end else if (shift == 8'hE1) begin
                // Pause is E1 followed by seven more bytes; swallow them all.
                skip_n = 3'd7;
            end else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (!repeat_make) begin
                    key_n = {~ps2_key[10], ~brk, ext, shift};
                    stb_n = 1'b1;
                end
                if (!brk) begin
                    held_n     = {ext, shift};
                    held_vld_n = 1'b1;
                end else if (held == {ext, shift}) begin
                    held_vld_n = 1'b0;
                end
`else
                key_n = {~ps2_key[10], ~brk, ext, shift};
                stb_n = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip      <= '0;
            ps2_key   <= '0;
            key_stb   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ext       <= ext_n;
            brk       <= brk_n;
            skip      <= skip_n;
            ps2_key   <= key_n;
            key_stb   <= stb_n;
            frame_err <= err_n;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            held     <= '0;
            held_vld <= 1'b0;
        end else begin
            held     <= held_n;
            held_vld <= held_vld_n;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed bench for ps2_key_gen: table of single-frame vectors plus hand sequences for timeout, reset and typematic.
module tb_ps2_key_gen;

    localparam int FILTER     = 8;
    localparam int TB_TIMEOUT = 2000;
    localparam int HALF       = 20;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int REP_STB = 1;
`else
    localparam int REP_STB = 3;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        key_stb;
    logic        frame_err;

    ps2_key_gen #(
        .FILTER (FILTER),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .key_stb  (key_stb),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  data;
        logic        bad_par;
        logic        bad_stop;
        logic        exp_stb;
        logic        exp_err;
        logic [10:0] exp_key;
    } vec_t;

    vec_t vecs[20];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stb_cnt  = 0;
    int err_cnt  = 0;
    int stb_wide = 0;
    int err_wide = 0;
    int last_stb_cyc = 0;
    int stop_cyc = 0;
    logic stb_prev = 1'b0;
    logic err_prev = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (key_stb === 1'b1) begin
            stb_cnt++;
            last_stb_cyc = cyc;
            if (stb_prev) stb_wide++;
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
            if (err_prev) err_wide++;
        end
        stb_prev = (key_stb === 1'b1);
        err_prev = (frame_err === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic bp, input logic bs,
                                input logic es, input logic ee, input logic [10:0] ek);
        vec_t v;
        v.data = d; v.bad_par = bp; v.bad_stop = bs;
        v.exp_stb = es; v.exp_err = ee; v.exp_key = ek;
        return v;
    endfunction

    // Frame bits in wire order: start, d0..d7, parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic bp, input logic bs);
        logic par;
        par = (~^b) ^ bp;
        return {~bs, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame_of(b, 1'b0, 1'b0), 11);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int s0, e0;
        s0 = stb_cnt;
        e0 = err_cnt;
        send_bits(frame_of(v.data, v.bad_par, v.bad_stop), 11);
        check($sformatf("vec%0d_stb", idx), stb_cnt - s0, 32'(v.exp_stb));
        check($sformatf("vec%0d_err", idx), err_cnt - e0, 32'(v.exp_err));
        check($sformatf("vec%0d_key", idx), 32'(ps2_key), 32'(v.exp_key));
        if (v.exp_stb) begin
            check($sformatf("vec%0d_latency", idx), last_stb_cyc - stop_cyc, FILTER + 2);
        end
    endtask

    initial begin
        int s0, e0;

        vecs[0]  = mk(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 11'h61C);
        vecs[1]  = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h61C);
        vecs[2]  = mk(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 11'h01C);
        vecs[3]  = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h01C);
        vecs[4]  = mk(8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 11'h775);
        vecs[5]  = mk(8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 11'h272);
        vecs[6]  = mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 11'h272);
        vecs[7]  = mk(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 11'h61C);
        vecs[8]  = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h61C);
        vecs[9]  = mk(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 11'h61C);
        vecs[10] = mk(8'h1B, 1'b0, 1'b0, 1'b1, 1'b0, 11'h21B);
        vecs[11] = mk(8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[12] = mk(8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[13] = mk(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[14] = mk(8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[15] = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[16] = mk(8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[17] = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[18] = mk(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 11'h629);
        vecs[19] = mk(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 11'h21C);

        repeat (5) @(negedge clk_sys);
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_stb", 32'(key_stb), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        for (int i = 0; i <= 10; i++) apply_vec(vecs[i], i);

        // Partial frame abandoned: only the timeout can recover it.
        s0 = stb_cnt;
        e0 = err_cnt;
        send_bits(frame_of(8'h33, 1'b0, 1'b0), 5);
        repeat (TB_TIMEOUT + 10) @(negedge clk_sys);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_stb", stb_cnt - s0, 0);
        check("timeout_key", 32'(ps2_key), 32'h21B);
        s0 = stb_cnt;
        send_byte(8'h29);
        check("after_timeout_stb", stb_cnt - s0, 1);
        check("after_timeout_key", 32'(ps2_key), 32'h629);

        for (int i = 11; i <= 19; i++) apply_vec(vecs[i], i);

        // Reset in the middle of the data bits.
        send_bits(frame_of(8'h1C, 1'b0, 1'b0), 4);
        @(negedge clk_sys);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("midreset_key", 32'(ps2_key), 32'h0);
        check("midreset_stb", 32'(key_stb), 32'h0);
        check("midreset_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        s0 = stb_cnt;
        e0 = err_cnt;
        send_byte(8'h1C);
        check("post_reset_stb", stb_cnt - s0, 1);
        check("post_reset_err", err_cnt - e0, 0);
        check("post_reset_key", 32'(ps2_key), 32'h61C);
        send_byte(8'h29);
        check("post_reset_key2", 32'(ps2_key), 32'h229);

        // Typematic repeats of the same make.
        s0 = stb_cnt;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        check("repeat_stb", stb_cnt - s0, REP_STB);
        check("repeat_key", 32'(ps2_key), 32'h61C);
        s0 = stb_cnt;
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("release_key", 32'(ps2_key), 32'h01C);
        send_byte(8'h1C);
        check("release_make_stb", stb_cnt - s0, 2);
        check("release_make_key", 32'(ps2_key), 32'h61C);

        check("stb_single_cycle", stb_wide, 0);
        check("err_single_cycle", err_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
